// File: rtl/des_round_engine.sv
// DES round engine: iterative Feistel datapath, RPC rounds per clock.
// One block in flight; valid/ready on both the input and output sides.
module des_round_engine #(
  parameter int ROUNDS = 16,
  parameter int RPC    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [1:64] data_in,
  input  logic [1:64] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] data_out,
  output logic        busy
);

  if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
    $error("des_round_engine: ROUNDS must be 1..16");
  end
  if (!(RPC == 1 || RPC == 2 || RPC == 4) ||
      (ROUNDS % RPC) != 0) begin : g_bad_rpc
    $error("des_round_engine: RPC must be 1/2/4 and divide ROUNDS");
  end

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Cumulative left-rotation per round, so any subkey is one rotate away.
  localparam logic [0:15][4:0] CSH = {
    5'd1,  5'd2,  5'd4,  5'd6,
    5'd8,  5'd10, 5'd12, 5'd14,
    5'd15, 5'd17, 5'd19, 5'd21,
    5'd23, 5'd25, 5'd27, 5'd28
  };

  // S1..S8, each 64 nibbles in row-major order (row = b1b6, col = b2..b5).
  localparam logic [0:7][0:63][3:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] pperm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      y[31-4*i -: 4] = SBOX[i][{b[5], b[0], b[4:1]}];
    end
    return y;
  endfunction

  function automatic logic [27:0] rotl28(
    input logic [27:0] x,
    input logic [4:0]  n
  );
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [47:0] subkey(
    input logic [27:0] c,
    input logic [27:0] d,
    input logic [4:0]  kr
  );
    logic [3:0] ki;
    logic [4:0] sh;
    ki = 4'(kr - 5'd1);
    sh = CSH[ki];
    return pc2({rotl28(c, sh), rotl28(d, sh)});
  endfunction

  function automatic logic [31:0] feistel(
    input logic [31:0] r,
    input logic [47:0] k
  );
    return pperm(sbox(expand(r) ^ k));
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      st, st_n;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        mode_q;
  logic [4:0]  cnt_q;
  logic [63:0] dout_q;
  logic        ov_q;

  logic        accept, step, take, last;
  logic [31:0] l_n, r_n, tmp;
  logic [4:0]  rnd, kr;

  assign accept = (st == IDLE) && in_valid;
  assign step   = (st == RUN);
  assign take   = (st == DONE) && out_ready;
  assign last   = (cnt_q == 5'(ROUNDS - RPC));

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:    if (in_valid)  st_n = RUN;
      RUN:     if (last)      st_n = DONE;
      DONE:    if (out_ready) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (st == IDLE);
    busy     = (st != IDLE);
  end

  // Decrypt walks the same schedule backwards: round r uses K(ROUNDS+1-r).
  always_comb begin
    l_n = l_q;
    r_n = r_q;
    tmp = '0;
    rnd = '0;
    kr  = '0;
    for (int j = 0; j < RPC; j++) begin
      rnd = cnt_q + 5'(j + 1);
      kr  = mode_q ? 5'(ROUNDS + 1) - rnd : rnd;
      tmp = r_n;
      r_n = l_n ^ feistel(r_n, subkey(c_q, d_q, kr));
      l_n = tmp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      dout_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          {l_q, r_q} <= ip(data_in);
          {c_q, d_q} <= pc1(key_in);
          mode_q     <= mode;
          cnt_q      <= '0;
        end
        step: begin
          l_q   <= l_n;
          r_q   <= r_n;
          cnt_q <= cnt_q + 5'(RPC);
          if (last) begin
            dout_q <= fp({r_n, l_n});
            ov_q   <= 1'b1;
          end
        end
        take: ov_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign data_out  = dout_q;
  assign out_valid = ov_q;

endmodule

// File: doc/des_round_engine.md
DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, giving the number of Feistel rounds per block; legal values are 1..16.
REQ-002 SHALL have parameter RPC, default 1, giving the rounds executed per clock; legal values are 1, 2 or 4, and RPC SHALL divide ROUNDS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the request carries a block.
REQ-006 SHALL have port in_ready, output, 1 bit: the engine can accept a block.
REQ-007 SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled on accept.
REQ-008 SHALL have port data_in, input, [1:64]: plaintext or ciphertext block; sampled on accept.
REQ-009 SHALL have port key_in, input, [1:64]: DES key including parity bits; sampled on accept.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port data_out, output, [1:64]: result block, registered.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 in_ready SHALL be 1 exactly when state is IDLE.
REQ-016 Accept occurs at a rising edge where in_valid && in_ready are both high.
REQ-017 On accept: latch IP(data_in) into L/R; latch PC1(key_in) into C0/D0; latch mode; clear the round counter; go to RUN.
REQ-018 The round function SHALL be built from the team's existing expansion, S1..S8 and P-permutation blocks: R_next = L xor P(S(E(R) xor K)), L_next = R.
REQ-019 Each RUN cycle SHALL apply RPC consecutive rounds combinationally, then advance the counter by RPC.
REQ-020 Round r (1..ROUNDS) SHALL use subkey K(r) = PC2(rotl(C0,S(r)) || rotl(D0,S(r))), where S(r) is the cumulative DES shift sum of the schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 In encrypt mode, round r SHALL use K(r); in decrypt mode, round r SHALL use K(ROUNDS+1-r).
REQ-022 After round ROUNDS: data_out <= FP(R||L), i.e. the final halves swapped; out_valid <= 1; go to DONE.
REQ-023 Latency from the accept edge to out_valid high SHALL be exactly ROUNDS/RPC cycles (16 by default).
REQ-024 In DONE, data_out and out_valid SHALL hold stable until out_ready is high at an edge; at that edge out_valid <= 0 and the state goes to IDLE.
REQ-025 in_valid SHALL be ignored in RUN and DONE; there is no back-to-back overlap, and the next accept is possible at the first IDLE cycle.
REQ-026 Changes on data_in, key_in or mode after accept SHALL NOT affect the result in flight.
REQ-027 Illegal ROUNDS or RPC values SHALL cause an elaboration-time error.

Reset
REQ-028 While rst is high at an edge: state <= IDLE, out_valid <= 0, data_out <= 0, round counter <= 0, L/R/C0/D0 <= 0; as a result in_ready = 1 and busy = 0 from the next cycle.
REQ-029 rst SHALL take priority over every other event, including an accept or output handshake on the same edge.
REQ-030 A reset in RUN or DONE SHALL discard the block in flight, with no out_valid pulse.

Verification
REQ-031 Encrypt, defaults, key 133457799BBCDFF1, in 0123456789ABCDEF -> out_valid 16 cycles after accept, data_out 85E813540F0AB405.
REQ-032 Decrypt, same key, in 85E813540F0AB405 -> data_out 0123456789ABCDEF; with RPC=4, the same result after 4 cycles.
REQ-033 out_ready held low for 10 cycles in DONE -> data_out stable, in_ready 0, in_valid ignored; out_ready high -> IDLE and in_ready 1 the next cycle.
REQ-034 rst asserted at RUN cycle 7 -> out_valid never rises, in_ready 1 after the reset edge, and the next block gives the correct result.
REQ-035 ROUNDS=4, random keys and blocks, both modes -> encrypt then decrypt round-trips to the original block in 1000 of 1000 trials; results match a software model.
